// File: rtl/csa_bit_iterator.sv
// Set-bit iterator: takes a vector plus its csa population count and emits the index of
// every set bit, LSB first, one beat per handshake, flagging a count mismatch on the last beat.
module csa_bit_iterator #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDXW  = $clog2(DEPTH),
    parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DEPTH-1:0] in_vec,
    input  logic [CNTW-1:0]  in_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             out_null,
    output logic [CNTW-1:0]  out_cnt,
    output logic             cnt_err
);

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    state_t            state_q;
    logic [DEPTH-1:0]  vec_q;
    logic [CNTW-1:0]   cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [IDXW-1:0]   out_idx_q;
    logic              out_last_q;
    logic              out_null_q;
    logic [CNTW-1:0]   out_cnt_q;
    logic              cnt_err_q;

    logic [DEPTH-1:0]  src_vec_d;
    logic              src_zero_d;
    logic              src_single_d;
    logic [IDXW-1:0]   src_idx_d;
    logic [CNTW-1:0]   run_cnt_d;

    function automatic logic [IDXW-1:0] lsb_index(input logic [DEPTH-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

    // Vector the next beat is decoded from: the incoming one when idle, else vec_q minus its lowest bit
    always_comb begin
        src_vec_d    = (state_q == ST_IDLE) ? in_vec : (vec_q & (vec_q - DEPTH'(1)));
        src_zero_d   = (src_vec_d == '0);
        src_single_d = !src_zero_d && ((src_vec_d & (src_vec_d - DEPTH'(1))) == '0);
        src_idx_d    = lsb_index(src_vec_d);
        run_cnt_d    = out_cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_null_q  <= 1'b0;
            out_cnt_q   <= '0;
            cnt_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        state_q     <= ST_EMIT;
                        in_ready_q  <= 1'b0;
                        vec_q       <= in_vec;
                        cnt_q       <= in_cnt;
                        out_valid_q <= 1'b1;
                        out_idx_q   <= src_idx_d;
                        out_last_q  <= src_zero_d || src_single_d;
                        out_null_q  <= src_zero_d;
                        out_cnt_q   <= src_zero_d ? CNTW'(0) : CNTW'(1);
                        cnt_err_q   <= src_zero_d ? (in_cnt != '0)
                                                  : (src_single_d && (in_cnt != CNTW'(1)));
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= ST_IDLE;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_idx_q   <= '0;
                            out_last_q  <= 1'b0;
                            out_null_q  <= 1'b0;
                            out_cnt_q   <= '0;
                            cnt_err_q   <= 1'b0;
                        end else begin
                            vec_q      <= src_vec_d;
                            out_idx_q  <= src_idx_d;
                            out_last_q <= src_single_d;
                            out_cnt_q  <= run_cnt_d;
                            cnt_err_q  <= src_single_d && (run_cnt_d != cnt_q);
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_null  = out_null_q;
    assign out_cnt   = out_cnt_q;
    assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_csa_bit_iterator.sv
// Directed bench for csa_bit_iterator: inputs driven and outputs checked on the falling edge.
module tb_csa_bit_iterator;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned IDXW  = 6;
    localparam int unsigned CNTW  = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DEPTH-1:0] in_vec;
    logic [CNTW-1:0]  in_cnt;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             out_null;
    logic [CNTW-1:0]  out_cnt;
    logic             cnt_err;

    int n_cmp = 0;
    int n_err = 0;

    csa_bit_iterator #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .in_cnt    (in_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_null  (out_null),
        .out_cnt   (out_cnt),
        .cnt_err   (cnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance
    task automatic send(input logic [DEPTH-1:0] v, input logic [CNTW-1:0] c);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_vec   = v;
        in_cnt   = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Check the beat currently presented, drive out_ready, advance one cycle
    task automatic beat(input string tag, input int idx, input bit last, input bit nul,
                        input int cnt, input bit err, input bit rdy);
        out_ready = rdy;
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".idx"},   64'(out_idx),   64'(idx));
        chk({tag, ".last"},  64'(out_last),  64'(last));
        chk({tag, ".null"},  64'(out_null),  64'(nul));
        chk({tag, ".cnt"},   64'(out_cnt),   64'(cnt));
        if (last) chk({tag, ".err"}, 64'(cnt_err), 64'(err));
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = '0;
        in_cnt    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst.in_ready",  64'(in_ready),  64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_idx",   64'(out_idx),   64'd0);
        chk("rst.out_cnt",   64'(out_cnt),   64'd0);
        chk("rst.flags",     64'({out_last, out_null, cnt_err}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.in_ready", 64'(in_ready), 64'd1);

        // Two bits, counts agree
        send(64'h0001_0001_0000_0000, 7'd2);
        beat("t1b0", 32, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        beat("t1b1", 48, 1'b1, 1'b0, 2, 1'b0, 1'b1);
        chk("t1.in_ready",  64'(in_ready),  64'd1);
        chk("t1.out_valid", 64'(out_valid), 64'd0);

        // All ones: 64 back-to-back beats
        send('1, 7'd64);
        for (int i = 0; i < 64; i++)
            beat($sformatf("t2b%0d", i), i, (i == 63), 1'b0, i + 1, 1'b0, 1'b1);
        chk("t2.out_valid", 64'(out_valid), 64'd0);

        // Zero vector, matching and mismatching counts
        send('0, 7'd0);
        beat("t3a", 0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        chk("t3a.done", 64'(out_valid), 64'd0);
        send('0, 7'd5);
        beat("t3b", 0, 1'b1, 1'b1, 0, 1'b1, 1'b1);
        chk("t3b.done", 64'(out_valid), 64'd0);

        // Four bits vs count 3; a stray in_valid while busy must be ignored
        send(64'h000f_0000_0000_0000, 7'd3);
        in_valid = 1'b1;
        in_vec   = 64'h1;
        in_cnt   = 7'd1;
        beat("t4b0", 48, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        beat("t4b1", 49, 1'b0, 1'b0, 2, 1'b0, 1'b1);
        beat("t4b2", 50, 1'b0, 1'b0, 3, 1'b0, 1'b1);
        in_valid = 1'b0;
        beat("t4b3", 51, 1'b1, 1'b0, 4, 1'b1, 1'b1);
        chk("t4.done", 64'(out_valid), 64'd0);

        // Stall on the last beat: out_ready 1,0,0,1
        send(64'h8000_0000_0000_0001, 7'd2);
        beat("t5b0",  0,  1'b0, 1'b0, 1, 1'b0, 1'b1);
        beat("t5s0",  63, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        beat("t5s1",  63, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        beat("t5b1",  63, 1'b1, 1'b0, 2, 1'b0, 1'b1);
        chk("t5.done", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t5.no_extra", 64'(out_valid), 64'd0);

        // Reset in the middle of a vector
        send('1, 7'd64);
        beat("t6b0", 0, 1'b0, 1'b0, 1, 1'b0, 1'b1);
        beat("t6b1", 1, 1'b0, 1'b0, 2, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6.rst_valid",    64'(out_valid), 64'd0);
        chk("t6.rst_in_ready", 64'(in_ready),  64'd0);
        chk("t6.rst_idx",      64'(out_idx),   64'd0);
        chk("t6.rst_cnt",      64'(out_cnt),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6.in_ready", 64'(in_ready), 64'd1);
        send(64'h10, 7'd1);
        beat("t6c", 4, 1'b1, 1'b0, 1, 1'b0, 1'b1);
        chk("t6.done", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
